// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: command op codes and controller state encodings for the JK register sequencer
package jk_seq_pkg;
  typedef enum logic [1:0] {OP_HOLD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_LOAD = 2'b11} op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop with asynchronous active-high reset to 0
module jk_cell (
  input  logic Clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Q
);
  always_ff @(posedge Clk or posedge rst)
    if (rst) Q <= 1'b0;
    else Q <= (J & ~Q) | (~K & Q);
endmodule

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: valid/ready command controller driving a bank of JK cells
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  state_t state, state_n;
  op_t op;
  logic [WIDTH-1:0] data, j, k, t_up, t_dn;
  logic [LEN_W-1:0] cnt;
  logic run, accept;
  assign cmd_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign run = state == S_RUN;
  assign accept = cmd_valid && cmd_ready;
  always_comb begin
    state_n = state;
    if (accept) state_n = (op_t'(cmd_op) != OP_LOAD && cmd_len == '0) ? S_DONE : S_RUN;
    else if (run && cnt == LEN_W'(1)) state_n = S_DONE;
    else if (state == S_DONE) state_n = S_IDLE;
  end
  // LOAD is treated as a one-step command so it shares the RUN exit condition
  always_ff @(posedge Clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      op <= OP_HOLD;
      data <= '0;
      cnt <= '0;
      wrap <= 1'b0;
    end else begin
      state <= state_n;
      wrap <= run && ((op == OP_UP && &Q) || (op == OP_DOWN && ~|Q));
      if (accept) begin
        op <= op_t'(cmd_op);
        data <= cmd_data;
        cnt <= op_t'(cmd_op) == OP_LOAD ? LEN_W'(1) : cmd_len;
      end else if (run) cnt <= cnt - 1'b1;
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      assign t_up[i] = 1'b1;
      assign t_dn[i] = 1'b1;
    end else begin : g_msb
      assign t_up[i] = &Q[i-1:0];
      assign t_dn[i] = ~|Q[i-1:0];
    end
    assign j[i] = run && (op == OP_LOAD ? data[i] : op == OP_UP ? t_up[i] : op == OP_DOWN && t_dn[i]);
    assign k[i] = run && (op == OP_LOAD ? !data[i] : op == OP_UP ? t_up[i] : op == OP_DOWN && t_dn[i]);
    jk_cell u_cell (.Clk(Clk), .rst(rst), .J(j[i]), .K(k[i]), .Q(Q[i]));
  end
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: randomized scoreboard bench against a modular-arithmetic command model
module tb_jk_bank_sequencer;
  typedef struct packed {
    logic [3:0] q;
    logic w;
    logic d;
    logic b;
    logic r;
  } exp_t;
  logic Clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_data = 4'd0;
  logic [7:0] cmd_len = 8'd0;
  logic cmd_ready, busy, done, wrap;
  logic [3:0] Q;
  int checks = 0;
  int failures = 0;
  int model_q = 0;
  exp_t sb[$];
  exp_t mon_got, mon_exp;
  jk_bank_sequencer #(.WIDTH(4), .LEN_W(8)) dut (
    .Clk(Clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .Q(Q), .busy(busy), .done(done), .wrap(wrap)
  );
  always #10 Clk = ~Clk;
  task automatic check(string name, logic [7:0] got, logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask
  // Monitor: one expected {Q,wrap,done,busy,ready} per cycle while a command is in flight, idle otherwise
  always @(negedge Clk) if (!rst) begin
    mon_got = {Q, wrap, done, busy, cmd_ready};
    if (sb.size() > 0) begin
      mon_exp = sb.pop_front();
      check("cycle", mon_got, mon_exp);
    end else begin
      mon_exp = {model_q[3:0], 4'b0001};
      check("idle", mon_got, mon_exp);
    end
  end
  task automatic push_model(logic [1:0] op, logic [3:0] data, logic [7:0] len);
    int q, n;
    bit w;
    q = model_q;
    if (op != 2'd3 && len == 8'd0) sb.push_back({q[3:0], 4'b0110});
    else begin
      n = (op == 2'd3) ? 1 : int'(len);
      sb.push_back({q[3:0], 4'b0010});
      for (int s = 1; s <= n; s++) begin
        w = 1'b0;
        if (op == 2'd3) q = int'(data);
        else if (op == 2'd1) begin w = (q == 15); q = (q + 1) % 16; end
        else if (op == 2'd2) begin w = (q == 0); q = (q + 15) % 16; end
        sb.push_back({q[3:0], w, s == n, 1'b1, 1'b0});
      end
    end
    sb.push_back({q[3:0], 4'b0001});
    model_q = q;
  endtask
  task automatic issue(logic [1:0] op, logic [3:0] data, logic [7:0] len, bit hold);
    int guard;
    guard = 0;
    @(negedge Clk);
    while (!cmd_ready && guard < 600) begin
      cmd_op = 2'($urandom);
      cmd_data = 4'($urandom);
      cmd_len = 8'($urandom);
      guard++;
      @(negedge Clk);
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: ready=%b expected 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    cmd_op = op;
    cmd_data = data;
    cmd_len = len;
    cmd_valid = 1'b1;
    @(posedge Clk);
    push_model(op, data, len);
    if (!hold) begin
      @(negedge Clk);
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom);
      cmd_len = 8'($urandom);
    end
  endtask
  task automatic drain();
    int g;
    g = 0;
    while (sb.size() > 0 && g < 1000) begin
      @(negedge Clk);
      g++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge Clk);
    check("reset_q", 8'(Q), 8'h0);
    check("reset_flags", {4'b0, wrap, done, busy, cmd_ready}, 8'h01);
    #3 rst = 1'b0;
    // Reset mid-command: immediate clear, then no done pulse (idle monitor checks)
    issue(2'd1, 4'h0, 8'd20, 1'b0);
    repeat (5) @(negedge Clk);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_q", 8'(Q), 8'h0);
    check("rst_mid_flags", {4'b0, wrap, done, busy, cmd_ready}, 8'h01);
    sb.delete();
    model_q = 0;
    @(negedge Clk);
    #3 rst = 1'b0;
    repeat (25) @(negedge Clk);
    issue(2'd3, 4'hA, 8'd0, 1'b0);
    drain();
    issue(2'd3, 4'hC, 8'd0, 1'b0);
    issue(2'd1, 4'h0, 8'd8, 1'b0);
    drain();
    issue(2'd3, 4'h1, 8'd0, 1'b0);
    issue(2'd2, 4'h0, 8'd3, 1'b0);
    drain();
    issue(2'd3, 4'h7, 8'd0, 1'b0);
    issue(2'd1, 4'h0, 8'd0, 1'b0);
    issue(2'd0, 4'hF, 8'd5, 1'b0);
    drain();
    issue(2'd3, 4'h3, 8'd0, 1'b1);
    issue(2'd1, 4'h0, 8'd2, 1'b0);
    drain();
    check("queued_final_q", 8'(Q), 8'h5);
    issue(2'd2, 4'h0, 8'd255, 1'b0);
    drain();
    for (int r = 0; r < 40; r++)
      issue(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
    @(negedge Clk);
    cmd_valid = 1'b0;
    drain();
    repeat (3) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
